// File: rtl/parking_gate_controller.sv
// parking_gate_controller
//
// Sequencing controller for the parking-lot entry and exit gates. It drives the
// timestamp buffer (store on entry, retrieve duration on exit), turns the returned
// duration into a fee, offers the fee to the payment unit over a valid/ack
// handshake and times the gate-open pulses.
//
// Ports
//   clk             in   clock, all logic on the rising edge
//   reset           in   synchronous active-high reset
//   entry_req       in   entry sensor request, sampled only while idle
//   exit_req        in   exit sensor request, sampled only while idle
//   req_car_id      in   car ID for the request (1..3 valid, 0 invalid)
//   ts_write_enable out  store-timestamp strobe to the buffer
//   ts_read_enable  out  retrieve-duration strobe to the buffer
//   ts_car_id       out  ID presented to the buffer (holds its last value)
//   ts_duration     in   duration from the buffer, valid in the read-strobe cycle
//   fee             out  amount due, stable while fee_valid is high
//   fee_valid       out  fee offered to the payment unit
//   fee_ack         in   payment accepted
//   entry_gate_open out  entry gate open command
//   exit_gate_open  out  exit gate open command
//   occupancy       out  number of cars present (0..3)
//   full            out  occupancy == 3
//   busy            out  sequencer not idle
//   error           out  one-cycle pulse for a rejected request
//   error_code      out  01 invalid ID, 10 duplicate entry, 11 exit of absent car

module parking_gate_controller #(
  parameter int unsigned RATE             = 2,
  parameter int unsigned FEE_W            = 16,
  parameter int unsigned GATE_OPEN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic [1:0]       req_car_id,
  output logic             ts_write_enable,
  output logic             ts_read_enable,
  output logic [1:0]       ts_car_id,
  input  logic [7:0]       ts_duration,
  output logic [FEE_W-1:0] fee,
  output logic             fee_valid,
  input  logic             fee_ack,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic [1:0]       occupancy,
  output logic             full,
  output logic             busy,
  output logic             error,
  output logic [1:0]       error_code
);

  // Gate-open down-counter: loaded with GATE_OPEN_CYCLES-1, the open state is
  // left in the cycle the counter reads zero.
  localparam int unsigned CntW = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(GATE_OPEN_CYCLES - 1);

  // The 8-bit duration times an 8-bit rate fits in 16 bits; widen to FEE_W if larger.
  localparam int unsigned ProdW = 16;
  localparam int unsigned WideW = (FEE_W > ProdW) ? FEE_W : ProdW;

  localparam logic [1:0] ErrInvalidId = 2'b01;
  localparam logic [1:0] ErrDuplicate = 2'b10;
  localparam logic [1:0] ErrAbsent    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StEntryWrite,
    StEntryOpen,
    StExitRead,
    StExitBill,
    StExitOpen
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       car_id_q, car_id_d;
  logic [2:0]       present_q, present_d;
  logic [1:0]       occ_q, occ_d;
  logic [FEE_W-1:0] fee_q, fee_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic [2:0]       req_mask;
  logic [2:0]       cur_mask;
  logic             req_id_valid;
  logic             req_present;
  logic [WideW-1:0] prod;
  logic [WideW-1:0] fee_max;
  logic [FEE_W-1:0] fee_calc;

  // ID n maps to present bit n-1; ID 0 selects nothing.
  always_comb begin
    req_mask = 3'b000;
    unique case (req_car_id)
      2'd1:    req_mask = 3'b001;
      2'd2:    req_mask = 3'b010;
      2'd3:    req_mask = 3'b100;
      default: req_mask = 3'b000;
    endcase
  end

  always_comb begin
    cur_mask = 3'b000;
    unique case (car_id_q)
      2'd1:    cur_mask = 3'b001;
      2'd2:    cur_mask = 3'b010;
      2'd3:    cur_mask = 3'b100;
      default: cur_mask = 3'b000;
    endcase
  end

  assign req_id_valid = (req_car_id != 2'd0);
  assign req_present  = |(present_q & req_mask);

  // Full-width product, saturated to all-ones of the fee width.
  always_comb begin
    prod     = WideW'(ts_duration) * WideW'(RATE);
    fee_max  = WideW'({FEE_W{1'b1}});
    fee_calc = prod[FEE_W-1:0];
    if (prod > fee_max) begin
      fee_calc = {FEE_W{1'b1}};
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    car_id_d        = car_id_q;
    present_d       = present_q;
    occ_d           = occ_q;
    fee_d           = fee_q;
    err_d           = 1'b0;
    code_d          = code_q;
    ts_write_enable = 1'b0;
    ts_read_enable  = 1'b0;
    fee_valid       = 1'b0;
    entry_gate_open = 1'b0;
    exit_gate_open  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Exit wins over a simultaneous entry since it frees a slot.
        if (exit_req) begin
          if (!req_id_valid) begin
            err_d  = 1'b1;
            code_d = ErrInvalidId;
          end else if (!req_present) begin
            err_d  = 1'b1;
            code_d = ErrAbsent;
          end else begin
            car_id_d = req_car_id;
            state_d  = StExitRead;
          end
        end else if (entry_req) begin
          if (!req_id_valid) begin
            err_d  = 1'b1;
            code_d = ErrInvalidId;
          end else if (req_present || (occ_q == 2'd3)) begin
            // With three IDs a full lot always implies a duplicate.
            err_d  = 1'b1;
            code_d = ErrDuplicate;
          end else begin
            car_id_d = req_car_id;
            state_d  = StEntryWrite;
          end
        end
      end

      StEntryWrite: begin
        ts_write_enable = 1'b1;
        present_d       = present_q | cur_mask;
        occ_d           = occ_q + 2'd1;
        cnt_d           = CntLoad;
        state_d         = StEntryOpen;
      end

      StEntryOpen: begin
        entry_gate_open = 1'b1;
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StExitRead: begin
        ts_read_enable = 1'b1;
        fee_d          = fee_calc;
        present_d      = present_q & ~cur_mask;
        occ_d          = occ_q - 2'd1;
        state_d        = StExitBill;
      end

      StExitBill: begin
        fee_valid = 1'b1;
        if (fee_ack) begin
          cnt_d   = CntLoad;
          state_d = StExitOpen;
        end
      end

      StExitOpen: begin
        exit_gate_open = 1'b1;
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      car_id_q  <= 2'd0;
      present_q <= 3'b000;
      occ_q     <= 2'd0;
      fee_q     <= '0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      car_id_q  <= car_id_d;
      present_q <= present_d;
      occ_q     <= occ_d;
      fee_q     <= fee_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign ts_car_id  = car_id_q;
  assign fee        = fee_q;
  assign occupancy  = occ_q;
  assign full       = (occ_q == 2'd3);
  assign busy       = (state_q != StIdle);
  assign error      = err_q;
  assign error_code = code_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
module tb_parking_gate_controller;

  localparam int G    = 4;
  localparam int MAXC = 512;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, entry_req, exit_req, fee_ack;
  logic [1:0] req_car_id;
  logic [7:0] ts_duration;

  // Instance A: RATE=2, instance B: RATE=255; same control behaviour.
  logic        a_we, a_re, a_fv, a_eg, a_xg, a_full, a_busy, a_err;
  logic [1:0]  a_id, a_occ, a_code;
  logic [15:0] a_fee;
  logic        b_we, b_re, b_fv, b_eg, b_xg, b_full, b_busy, b_err;
  logic [1:0]  b_id, b_occ, b_code;
  logic [15:0] b_fee;

  parking_gate_controller #(.RATE(2), .FEE_W(16), .GATE_OPEN_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .req_car_id(req_car_id), .ts_write_enable(a_we), .ts_read_enable(a_re),
    .ts_car_id(a_id), .ts_duration(ts_duration), .fee(a_fee), .fee_valid(a_fv),
    .fee_ack(fee_ack), .entry_gate_open(a_eg), .exit_gate_open(a_xg),
    .occupancy(a_occ), .full(a_full), .busy(a_busy), .error(a_err), .error_code(a_code)
  );

  parking_gate_controller #(.RATE(255), .FEE_W(16), .GATE_OPEN_CYCLES(G)) dut255 (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .req_car_id(req_car_id), .ts_write_enable(b_we), .ts_read_enable(b_re),
    .ts_car_id(b_id), .ts_duration(ts_duration), .fee(b_fee), .fee_valid(b_fv),
    .fee_ack(fee_ack), .entry_gate_open(b_eg), .exit_gate_open(b_xg),
    .occupancy(b_occ), .full(b_full), .busy(b_busy), .error(b_err), .error_code(b_code)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected-output timeline, one entry per cycle.
  bit          e_we[MAXC], e_re[MAXC], e_eg[MAXC], e_xg[MAXC];
  bit          e_fv[MAXC], e_busy[MAXC], e_err[MAXC];
  logic [1:0]  e_id[MAXC], e_occ[MAXC], e_code[MAXC];
  logic [15:0] e_fee2[MAXC], e_fee255[MAXC];

  // Transaction-level lot state.
  int m_present[4];
  int m_occ;
  int idle_from;
  int bill_start;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic m_error(input int n, input int code);
    if (n + 1 < MAXC) e_err[n+1] = 1'b1;
    for (int t = n + 1; t < MAXC; t++) e_code[t] = 2'(code);
  endtask

  task automatic m_entry(input int n, input int id);
    if (n + 1 < MAXC) e_we[n+1] = 1'b1;
    for (int t = n + 1; t <= n + 1 + G && t < MAXC; t++) e_busy[t] = 1'b1;
    for (int t = n + 2; t <= n + 1 + G && t < MAXC; t++) e_eg[t] = 1'b1;
    for (int t = n + 1; t < MAXC; t++) e_id[t] = 2'(id);
    m_present[id] = 1;
    m_occ++;
    for (int t = n + 2; t < MAXC; t++) e_occ[t] = 2'(m_occ);
    idle_from = n + 2 + G;
  endtask

  task automatic m_exit(input int n, input int id, input int dur);
    int f2;
    f2 = dur * 2;
    if (f2 > 65535) f2 = 65535;
    if (n + 1 < MAXC) e_re[n+1] = 1'b1;
    for (int t = n + 1; t < MAXC; t++) e_busy[t] = 1'b1;
    for (int t = n + 2; t < MAXC; t++) e_fv[t] = 1'b1;
    for (int t = n + 1; t < MAXC; t++) e_id[t] = 2'(id);
    for (int t = n + 2; t < MAXC; t++) begin
      e_fee2[t]   = 16'(f2);
      e_fee255[t] = 16'(dur * 255);
    end
    m_present[id] = 0;
    m_occ--;
    for (int t = n + 2; t < MAXC; t++) e_occ[t] = 2'(m_occ);
    bill_start = n + 2;
    idle_from  = MAXC;
  endtask

  task automatic m_req(input bit e, input bit x, input int id, input int n, input int dur);
    if (!e && !x) return;
    if (n < idle_from) return;  // dropped while busy
    if (x) begin
      if (id == 0) m_error(n, 1);
      else if (m_present[id] == 0) m_error(n, 3);
      else m_exit(n, id, dur);
    end else begin
      if (id == 0) m_error(n, 1);
      else if (m_present[id] != 0 || m_occ == 3) m_error(n, 2);
      else m_entry(n, id);
    end
  endtask

  task automatic m_ack(input int m);
    if (bill_start < 0 || m < bill_start) return;
    for (int t = m + 1; t < MAXC; t++) e_fv[t] = 1'b0;
    for (int t = m + G + 1; t < MAXC; t++) e_busy[t] = 1'b0;
    for (int t = m + 1; t <= m + G && t < MAXC; t++) e_xg[t] = 1'b1;
    idle_from  = m + G + 1;
    bill_start = -1;
  endtask

  task automatic m_reset(input int r);
    for (int t = r + 1; t < MAXC; t++) begin
      e_we[t] = 0; e_re[t] = 0; e_eg[t] = 0; e_xg[t] = 0;
      e_fv[t] = 0; e_busy[t] = 0; e_err[t] = 0;
      e_id[t] = 0; e_occ[t] = 0; e_code[t] = 0;
      e_fee2[t] = 0; e_fee255[t] = 0;
    end
    for (int i = 0; i < 4; i++) m_present[i] = 0;
    m_occ      = 0;
    idle_from  = r + 1;
    bill_start = -1;
  endtask

  task automatic check_dut(input string tag, input logic we, input logic re,
                           input logic [1:0] id, input logic [15:0] fee, input logic fv,
                           input logic eg, input logic xg, input logic [1:0] occ,
                           input logic full, input logic busy, input logic err,
                           input logic [1:0] code, input logic [15:0] efee);
    chk({tag, ".ts_write_enable"}, 32'(we), 32'(e_we[cyc]));
    chk({tag, ".ts_read_enable"}, 32'(re), 32'(e_re[cyc]));
    chk({tag, ".ts_car_id"}, 32'(id), 32'(e_id[cyc]));
    chk({tag, ".fee_valid"}, 32'(fv), 32'(e_fv[cyc]));
    if (e_fv[cyc]) chk({tag, ".fee"}, 32'(fee), 32'(efee));
    chk({tag, ".entry_gate_open"}, 32'(eg), 32'(e_eg[cyc]));
    chk({tag, ".exit_gate_open"}, 32'(xg), 32'(e_xg[cyc]));
    chk({tag, ".occupancy"}, 32'(occ), 32'(e_occ[cyc]));
    chk({tag, ".full"}, 32'(full), 32'(e_occ[cyc] == 2'd3));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy[cyc]));
    chk({tag, ".error"}, 32'(err), 32'(e_err[cyc]));
    chk({tag, ".error_code"}, 32'(code), 32'(e_code[cyc]));
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check_dut("a", a_we, a_re, a_id, a_fee, a_fv, a_eg, a_xg, a_occ, a_full, a_busy,
                a_err, a_code, e_fee2[cyc]);
      check_dut("b", b_we, b_re, b_id, b_fee, b_fv, b_eg, b_xg, b_occ, b_full, b_busy,
                b_err, b_code, e_fee255[cyc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_req(input bit e, input bit x, input int id);
    m_req(e, x, id, cyc, int'(ts_duration));
    entry_req  = e;
    exit_req   = x;
    req_car_id = 2'(id);
    step();
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    req_car_id = 2'd0;
  endtask

  task automatic do_ack();
    m_ack(cyc);
    fee_ack = 1'b1;
    step();
    fee_ack = 1'b0;
  endtask

  task automatic do_reset();
    m_reset(cyc);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; fee_ack = 1'b0;
    req_car_id = 2'd0; ts_duration = 8'd0;
    for (int i = 0; i < 4; i++) m_present[i] = 0;
    m_occ = 0; idle_from = 0; bill_start = -1;
    step();
    m_reset(0);
    chk_en = 1'b1;
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_occ", 32'(a_occ), 32'd0);
    step();
    reset = 1'b0;

    // Entry ID 2.
    do_req(1'b1, 1'b0, 2);
    chk("lit_entry_we", 32'(a_we), 32'd1);
    chk("lit_entry_id", 32'(a_id), 32'd2);
    idle(6);
    chk("lit_occ_after_entry", 32'(a_occ), 32'd1);

    // Exit ID 2, duration 10, ack three cycles after fee_valid rises.
    ts_duration = 8'd10;
    do_req(1'b0, 1'b1, 2);
    idle(4);
    chk("lit_fee_20", 32'(a_fee), 32'd20);
    chk("lit_fee_2550", 32'(b_fee), 32'd2550);
    do_ack();
    chk("lit_exit_gate", 32'(a_xg), 32'd1);
    idle(5);
    chk("lit_occ_after_exit", 32'(a_occ), 32'd0);

    // Fill the lot, then a duplicate entry on a full lot.
    for (int id = 1; id <= 3; id++) begin
      do_req(1'b1, 1'b0, id);
      idle(6);
    end
    chk("lit_full", 32'(a_full), 32'd1);
    do_req(1'b1, 1'b0, 1);
    chk("lit_dup_error", 32'(a_err), 32'd1);
    chk("lit_dup_code", 32'(a_code), 32'd2);
    chk("lit_dup_busy", 32'(a_busy), 32'd0);
    // Invalid IDs, the second one sampled in the error cycle.
    do_req(1'b1, 1'b0, 0);
    chk("lit_bad_id_code", 32'(a_code), 32'd1);
    do_req(1'b0, 1'b1, 0);
    idle(1);

    // Remove car 3, then exit of absent car 3.
    ts_duration = 8'd5;
    do_req(1'b0, 1'b1, 3);
    idle(2);
    do_ack();
    idle(5);
    do_req(1'b0, 1'b1, 3);
    chk("lit_absent_code", 32'(a_code), 32'd3);
    idle(1);

    // Simultaneous requests with car 1 present, requests while busy, ack in first cycle.
    ts_duration = 8'd255;
    do_req(1'b1, 1'b1, 1);
    chk("lit_prio_read", 32'(a_re), 32'd1);
    do_req(1'b0, 1'b1, 2);
    chk("lit_fee_65025", 32'(b_fee), 32'd65025);
    chk("lit_fee_510", 32'(a_fee), 32'd510);
    do_ack();
    do_req(1'b1, 1'b0, 3);
    idle(5);
    do_ack();
    idle(1);
    chk("lit_occ_one", 32'(a_occ), 32'd1);

    // Reset while the fee is being offered.
    do_req(1'b1, 1'b0, 1);
    idle(6);
    ts_duration = 8'd7;
    do_req(1'b0, 1'b1, 2);
    idle(3);
    chk("lit_bill_valid", 32'(a_fv), 32'd1);
    do_reset();
    chk("lit_rst_fv", 32'(a_fv), 32'd0);
    chk("lit_rst_occ", 32'(a_occ), 32'd0);
    chk("lit_rst_gate", 32'(a_xg | a_eg), 32'd0);
    do_req(1'b1, 1'b0, 1);
    chk("lit_rst_present", 32'(a_we), 32'd1);
    idle(6);
    chk("lit_final_occ", 32'(a_occ), 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
